// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game sequencer.
// Draws a random delay from the LFSR, waits with the GO LED dark, lights the
// LED and measures the player's reaction in ms. A false start or a timeout is
// flagged. All outputs are registered.
// Optional best-time tracking is enabled by defining REACT_BEST_TIME_EN,
// which adds the best_ms and new_best outputs.
module reaction_timer_ctrl #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 500,
  parameter int unsigned MAX_DELAY_MS = 5000,
  parameter int unsigned MAX_REACT_MS = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        react,
  input  logic [11:0] lfsr_value,
  output logic        lfsr_enable,
  output logic        led_go,
  output logic [13:0] reaction_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout,
  output logic        busy
`ifdef REACT_BEST_TIME_EN
  ,
  output logic [13:0] best_ms,
  output logic        new_best
`endif
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WAIT,
    S_GO,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [11:0]    dly_q, dly_d;
  logic [13:0]    ms_q, ms_d;
  logic [13:0]    reaction_q, reaction_d;
  logic           fs_q, fs_d;
  logic           to_q, to_d;
  logic           lfsr_en_q, lfsr_en_d;
  logic           led_go_q, led_go_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
`ifdef REACT_BEST_TIME_EN
  logic [13:0]    best_q, best_d;
  logic           nb_q, nb_d;
`endif

  logic           tick;
  logic           in_range;
  logic           reaching_max;
  logic [13:0]    react_val;

  assign tick         = (presc_q == PW'(TICK_DIV - 1));
  assign in_range     = ({20'd0, lfsr_value} >= MIN_DELAY_MS) &&
                        ({20'd0, lfsr_value} <= MAX_DELAY_MS);
  assign reaching_max = tick && (ms_q == 14'(MAX_REACT_MS - 1));
  // A react on the tick that reaches the limit reports the saturated value.
  assign react_val    = reaching_max ? 14'(MAX_REACT_MS) : ms_q;

  // Next-state, counter and result logic; outputs derive from the next state
  // so that each registered output lines up with the registered state.
  always_comb begin
    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    dly_d      = dly_q;
    ms_d       = ms_q;
    reaction_d = reaction_q;
    fs_d       = fs_q;
    to_d       = to_q;
`ifdef REACT_BEST_TIME_EN
    best_d     = best_q;
    nb_d       = nb_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_SEED;
          reaction_d = '0;
          fs_d       = 1'b0;
          to_d       = 1'b0;
`ifdef REACT_BEST_TIME_EN
          nb_d       = 1'b0;
`endif
        end
      end
      S_SEED: begin
        if (in_range) begin
          state_d = S_WAIT;
          dly_d   = lfsr_value;
          presc_d = '0;
        end
      end
      S_WAIT: begin
        if (react) begin
          state_d    = S_DONE;
          fs_d       = 1'b1;
          reaction_d = '0;
        end else if (tick) begin
          if (dly_q == 12'd1) begin
            state_d = S_GO;
            presc_d = '0;
            ms_d    = '0;
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
      end
      S_GO: begin
        if (react) begin
          state_d    = S_DONE;
          reaction_d = react_val;
`ifdef REACT_BEST_TIME_EN
          if (react_val < best_q) begin
            best_d = react_val;
            nb_d   = 1'b1;
          end
`endif
        end else if (reaching_max) begin
          state_d    = S_DONE;
          reaction_d = 14'(MAX_REACT_MS);
          to_d       = 1'b1;
        end else if (tick) begin
          ms_d = ms_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    lfsr_en_d = (state_d == S_IDLE) || (state_d == S_SEED) || (state_d == S_DONE);
    led_go_d  = (state_d == S_GO);
    valid_d   = (state_d == S_DONE);
    busy_d    = (state_d == S_SEED) || (state_d == S_WAIT) || (state_d == S_GO);
  end

  // State, counters and registered outputs; reset aborts any round.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      dly_q      <= '0;
      ms_q       <= '0;
      reaction_q <= '0;
      fs_q       <= 1'b0;
      to_q       <= 1'b0;
      lfsr_en_q  <= 1'b0;
      led_go_q   <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef REACT_BEST_TIME_EN
      best_q     <= 14'(MAX_REACT_MS);
      nb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      dly_q      <= dly_d;
      ms_q       <= ms_d;
      reaction_q <= reaction_d;
      fs_q       <= fs_d;
      to_q       <= to_d;
      lfsr_en_q  <= lfsr_en_d;
      led_go_q   <= led_go_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
`ifdef REACT_BEST_TIME_EN
      best_q     <= best_d;
      nb_q       <= nb_d;
`endif
    end
  end

  assign lfsr_enable  = lfsr_en_q;
  assign led_go       = led_go_q;
  assign reaction_ms  = reaction_q;
  assign result_valid = valid_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;
  assign busy         = busy_q;
`ifdef REACT_BEST_TIME_EN
  assign best_ms      = best_q;
  assign new_best     = nb_q;
`endif

endmodule
